// File: rtl/updi_pkg.sv
// Shared UPDI definitions: FSM states, 12-bit frame layout and frame helpers
// used by the transmitter and the command generator.
package updi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TURN  = 2'd2,
    ST_BREAK = 2'd3
  } updi_state_e;

  localparam int          FRAME_BITS   = 12;
  localparam int          POS_START    = 11;
  localparam int          POS_D_LSB    = 3;
  localparam int          POS_PARITY   = 2;
  localparam int          POS_STOP_LSB = 0;
  localparam logic [3:0]  LAST_BIT_IDX = 4'd11;
  localparam logic [7:0]  SYNC_BYTE    = 8'h55;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b0, b, ^b, 2'b11};
  endfunction

  function automatic logic [FRAME_BITS-1:0] make_sync_frame();
    return make_frame(SYNC_BYTE);
  endfunction

  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[POS_START] == 1'b0) &&
           (f[POS_STOP_LSB +: 2] == 2'b11) &&
           (f[POS_PARITY] == ^f[POS_D_LSB +: 8]);
  endfunction

  // Reorders a frame into line order (start, D0..D7, parity, stop, stop), MSB first.
  function automatic logic [FRAME_BITS-1:0] frame_to_wire(input logic [FRAME_BITS-1:0] f);
    logic [FRAME_BITS-1:0] w;
    w[FRAME_BITS-1] = f[POS_START];
    for (int i = 0; i < 8; i++) begin
      w[FRAME_BITS-2-i] = f[POS_D_LSB+i];
    end
    w[2]   = f[POS_PARITY];
    w[1:0] = f[POS_STOP_LSB +: 2];
    return w;
  endfunction

endpackage

// File: rtl/updi_baud_gen.sv
// Bit-time tick generator: counts 0..CLK_DIV-1 and ticks on the last count.
// A synchronous restart aligns the bit grid to the start of a new bit.
module updi_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/updi_tx.sv
// UPDI transmitter: one-entry holding register, 12-bit frame shifter,
// turnaround before releasing the line, and BREAK generation.
module updi_tx
  import updi_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int BREAK_BITS = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [FRAME_BITS-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_trans_en,
  input  logic                  i_break,
  output logic                  o_tx,
  output logic                  o_tx_oe,
  output logic                  o_done,
  output logic                  o_frame_err
);

  localparam int            BW      = $clog2(BREAK_BITS + 1);
  localparam logic [BW-1:0] BRK_END = BW'(BREAK_BITS);

  updi_state_e           r_state, w_state_nxt;
  logic                  r_hold_vld;
  logic [FRAME_BITS-1:0] r_hold_data;
  logic                  r_hold_last;
  logic [FRAME_BITS-1:0] r_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_last;
  logic                  r_brk_pend;
  logic [BW-1:0]         r_brk_cnt;
  logic                  r_oe;
  logic                  r_done;
  logic                  r_ferr;

  logic w_tick, w_accept, w_frame_ok, w_brk_req, w_flush;
  logic w_load, w_shift, w_restart, w_oe_nxt, w_done_nxt, w_brk_go, w_brk_step;

  updi_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  assign o_ready    = !r_hold_vld && (r_state != ST_BREAK) && !r_brk_pend;
  assign w_accept   = i_valid && o_ready;
  assign w_frame_ok = frame_ok(i_data);
  assign w_brk_req  = i_break || r_brk_pend;
  // A pending or active BREAK owns the line, so any held frame is dropped.
  assign w_flush    = r_brk_pend || (r_state == ST_BREAK) || w_brk_go;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_restart   = 1'b0;
    w_oe_nxt    = r_oe;
    w_done_nxt  = 1'b0;
    w_brk_go    = 1'b0;
    w_brk_step  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_brk_req) begin
          w_state_nxt = ST_BREAK;
          w_brk_go    = 1'b1;
          w_restart   = 1'b1;
          w_oe_nxt    = 1'b1;
        end else if (r_hold_vld) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
          w_restart   = 1'b1;
          w_oe_nxt    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_bit_cnt != LAST_BIT_IDX) begin
            w_shift = 1'b1;
          end else if (r_hold_vld) begin
            w_load    = 1'b1;
            w_restart = 1'b1;
          end else if (r_last) begin
            w_state_nxt = ST_TURN;
            w_restart   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_oe_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      ST_BREAK: begin
        if (w_tick) begin
          if (r_brk_cnt == BRK_END) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_brk_step = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_oe    <= w_oe_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_accept && !w_frame_ok;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
    end else begin
      if (w_load || w_flush) begin
        r_hold_vld <= 1'b0;
      end
      if (w_accept && w_frame_ok) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= i_data;
        r_hold_last <= i_trans_en;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
    end else if (w_load) begin
      r_shift   <= frame_to_wire(r_hold_data);
      r_bit_cnt <= '0;
      r_last    <= r_hold_last;
    end else if (w_shift) begin
      r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b1};
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_brk_pend <= 1'b0;
      r_brk_cnt  <= '0;
    end else begin
      if (w_brk_go) begin
        r_brk_pend <= 1'b0;
      end else if (i_break) begin
        r_brk_pend <= 1'b1;
      end
      if (w_brk_go) begin
        r_brk_cnt <= '0;
      end else if (w_brk_step) begin
        r_brk_cnt <= r_brk_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    o_tx = 1'b1;
    unique case (r_state)
      ST_SHIFT: o_tx = r_shift[FRAME_BITS-1];
      ST_BREAK: o_tx = (r_brk_cnt == BRK_END);
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_tx_oe     = r_oe;
  assign o_done      = r_done;
  assign o_frame_err = r_ferr;

endmodule

// File: tb/tb_updi_tx.sv
// Directed bench for updi_tx: table of single frames plus hand-written
// streaming, BREAK, mid-frame reset and CLK_DIV=2 sequences.
module tb_updi_tx;

  localparam int TX = 0, OE = 1, DN = 2, RDY = 3;
  localparam int RS = 4096;

  typedef struct {
    logic [11:0] frame;
    logic [11:0] wire_exp;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data;
  logic        valid, trans_en, brk, sel;

  logic tx4, oe4, rdy4, done4, ferr4;
  logic tx2, oe2, rdy2, done2, ferr2;
  logic tx, oe, rdy, done, ferr;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic rec_tx [RS];
  logic rec_oe [RS];
  logic rec_dn [RS];
  logic rec_rdy[RS];
  logic rec_fe [RS];

  always #5 clk = ~clk;

  updi_tx #(.CLK_DIV(4), .BREAK_BITS(24)) dut4 (
    .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_valid(valid & ~sel),
    .o_ready(rdy4), .i_trans_en(trans_en), .i_break(brk & ~sel),
    .o_tx(tx4), .o_tx_oe(oe4), .o_done(done4), .o_frame_err(ferr4)
  );

  updi_tx #(.CLK_DIV(2), .BREAK_BITS(24)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_valid(valid & sel),
    .o_ready(rdy2), .i_trans_en(trans_en), .i_break(brk & sel),
    .o_tx(tx2), .o_tx_oe(oe2), .o_done(done2), .o_frame_err(ferr2)
  );

  assign tx   = sel ? tx2   : tx4;
  assign oe   = sel ? oe2   : oe4;
  assign rdy  = sel ? rdy2  : rdy4;
  assign done = sel ? done2 : done4;
  assign ferr = sel ? ferr2 : ferr4;

  always @(negedge clk) begin
    rec_tx [cyc % RS] <= tx;
    rec_oe [cyc % RS] <= oe;
    rec_dn [cyc % RS] <= done;
    rec_rdy[cyc % RS] <= rdy;
    rec_fe [cyc % RS] <= ferr;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int seg_bad(input int b, input int j0, input int n, input logic v, input int sig);
    int   c;
    logic s;
    c = 0;
    for (int j = j0; j < j0 + n; j++) begin
      case (sig)
        TX:      s = rec_tx [(b + j) % RS];
        OE:      s = rec_oe [(b + j) % RS];
        DN:      s = rec_dn [(b + j) % RS];
        default: s = rec_rdy[(b + j) % RS];
      endcase
      if (s !== v) c++;
    end
    return c;
  endfunction

  task automatic send(input logic [11:0] f, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    while (rdy !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("ready_timeout", {31'd0, rdy}, 32'd1);
    data     = f;
    valid    = 1'b1;
    trans_en = last;
    @(posedge clk);
    #1;
    valid    = 1'b0;
    trans_en = 1'b0;
  endtask

  task automatic wait_samples(input int b, input int n);
    int g;
    g = 0;
    while (cyc < b + n && g < n + 20) begin
      @(negedge clk);
      g++;
    end
    if (cyc < b + n) check("sample_timeout", cyc - b, n);
  endtask

  task automatic check_wire(input int b, input int j0, input logic [11:0] w, input int d, input string tag);
    logic [11:0] got;
    int          bad;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      got[11-k] = rec_tx[(b + j0 + k * d) % RS];
      bad += seg_bad(b, j0 + k * d, d, w[11-k], TX);
    end
    check({tag, "_bits"}, {20'd0, got}, {20'd0, w});
    check({tag, "_bit_width"}, bad, 0);
  endtask

  // Single transaction: accept, transmit, one bit of turnaround, release.
  task automatic run_frame(input vec_t v, input int d, input string tag);
    int b;
    send(v.frame, 1'b1);
    b = cyc;
    if (!v.err) begin
      wait_samples(b, 13 * d + 3);
      check({tag, "_ferr"}, {31'd0, rec_fe[b % RS]}, 32'd0);
      check({tag, "_pre_start"}, {31'd0, rec_tx[b % RS]}, 32'd1);
      check_wire(b, 1, v.wire_exp, d, tag);
      check({tag, "_oe_hold"}, seg_bad(b, 1, 13 * d, 1'b1, OE), 0);
      check({tag, "_turn"}, seg_bad(b, 12 * d + 1, d, 1'b1, TX), 0);
      check({tag, "_release"}, {30'd0, rec_oe[(b + 13 * d + 1) % RS], rec_dn[(b + 13 * d + 1) % RS]}, 32'b01);
      check({tag, "_done_cnt"}, seg_bad(b, 0, 13 * d + 3, 1'b0, DN), 1);
    end else begin
      wait_samples(b, 3 * d + 1);
      check({tag, "_ferr"}, {30'd0, rec_fe[b % RS], rec_fe[(b + 1) % RS]}, 32'b10);
      check({tag, "_line_idle"}, seg_bad(b, 0, 3 * d + 1, 1'b1, TX), 0);
      check({tag, "_oe_off"}, seg_bad(b, 0, 3 * d + 1, 1'b0, OE), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   b;

    tbl[0] = '{12'b0_01010101_0_11, 12'b0_10101010_0_11, 1'b0};  // 0x55
    tbl[1] = '{12'b0_00000001_1_11, 12'b0_10000000_1_11, 1'b0};  // 0x01
    tbl[2] = '{12'b0_00000001_0_11, 12'hFFF,             1'b1};  // bad parity
    tbl[3] = '{12'b0_10100011_0_11, 12'b0_11000101_0_11, 1'b0};  // 0xA3
    tbl[4] = '{12'b1_00110011_0_11, 12'hFFF,             1'b1};  // bad start
    tbl[5] = '{12'b0_00110011_0_10, 12'hFFF,             1'b1};  // bad stop
    tbl[6] = '{12'b0_11111111_0_11, 12'b0_11111111_0_11, 1'b0};  // 0xFF
    tbl[7] = '{12'b0_10000000_1_11, 12'b0_00000001_1_11, 1'b0};  // 0x80
    tbl[8] = '{12'b0_00000000_0_11, 12'b0_00000000_0_11, 1'b0};  // 0x00

    rst_n = 1'b0; data = '0; valid = 1'b0; trans_en = 1'b0; brk = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, tx, oe, rdy, done, ferr}, 32'b10100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i], 4, $sformatf("v%0d", i));
    end

    // Three streamed frames, only the last closes the transaction.
    send(tbl[0].frame, 1'b0);
    b = cyc;
    send(tbl[1].frame, 1'b0);
    send(tbl[3].frame, 1'b1);
    wait_samples(b, 151);
    check("st_pre_start", {31'd0, rec_tx[b % RS]}, 32'd1);
    check_wire(b, 1,  tbl[0].wire_exp, 4, "st1");
    check_wire(b, 49, tbl[1].wire_exp, 4, "st2");
    check_wire(b, 97, tbl[3].wire_exp, 4, "st3");
    check("st_turn", seg_bad(b, 145, 4, 1'b1, TX), 0);
    check("st_oe_hold", seg_bad(b, 1, 148, 1'b1, OE), 0);
    check("st_release", {30'd0, rec_oe[(b + 149) % RS], rec_dn[(b + 149) % RS]}, 32'b01);
    check("st_done_cnt", seg_bad(b, 0, 151, 1'b0, DN), 1);

    // BREAK requested mid-frame waits for the frame, then runs.
    send(tbl[0].frame, 1'b0);
    b = cyc;
    wait_samples(b, 10);
    brk = 1'b1;
    @(posedge clk);
    #1;
    brk = 1'b0;
    wait_samples(b, 152);
    check_wire(b, 1, tbl[0].wire_exp, 4, "brk_frame");
    check("brk_gap", seg_bad(b, 49, 1, 1'b1, TX), 0);
    check("brk_low", seg_bad(b, 50, 96, 1'b0, TX), 0);
    check("brk_high", seg_bad(b, 146, 4, 1'b1, TX), 0);
    check("brk_oe_hold", seg_bad(b, 1, 149, 1'b1, OE), 0);
    check("brk_ready_low", seg_bad(b, 50, 100, 1'b0, RDY), 0);
    check("brk_release", {30'd0, rec_oe[(b + 150) % RS], rec_dn[(b + 150) % RS]}, 32'b01);
    check("brk_done_cnt", seg_bad(b, 0, 152, 1'b0, DN), 1);

    // Reset in the middle of bit 5.
    send(tbl[0].frame, 1'b1);
    b = cyc;
    wait_samples(b, 23);
    check("rst_pre_oe", {31'd0, oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {27'd0, tx, oe, rdy, done, ferr}, 32'b10100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    wait_samples(b, 12);
    check("rst_after_tx", seg_bad(b, 0, 12, 1'b1, TX), 0);
    check("rst_after_oe", seg_bad(b, 0, 12, 1'b0, OE), 0);
    run_frame(tbl[3], 4, "rst_next");

    // CLK_DIV = 2 boundary.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(tbl[0], 2, "d2_55");
    run_frame(tbl[3], 2, "d2_a3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
